// File: rtl/philox_pkg.sv
// Shared constants and FSM encoding for the Philox-4x32 stream generator.
package philox_pkg;
  localparam int STATE_W = 128;
  localparam int KEY_W   = 64;

  localparam logic [31:0] PHILOX_M0 = 32'hD2511F53;
  localparam logic [31:0] PHILOX_M1 = 32'hCD9E8D57;
  localparam logic [31:0] PHILOX_W0 = 32'h9E3779B9;
  localparam logic [31:0] PHILOX_W1 = 32'hBB67AE85;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } philox_state_e;
endpackage

// File: rtl/philox_round.sv
// One combinational Philox-4x32 round: permuted multiply/xor of the state plus key bump.
module philox_round
  import philox_pkg::*;
(
  input  logic [STATE_W-1:0] x_i,
  input  logic [KEY_W-1:0]   k_i,
  output logic [STATE_W-1:0] x_o,
  output logic [KEY_W-1:0]   k_o
);
  logic [63:0] p0;
  logic [63:0] p1;

  always_comb begin
    p0 = {32'd0, x_i[31:0]}  * {32'd0, PHILOX_M0};
    p1 = {32'd0, x_i[95:64]} * {32'd0, PHILOX_M1};
    // Word order (MSB first): y3 = lo0, y2 = hi0^x3^k1, y1 = lo1, y0 = hi1^x1^k0
    x_o = {p0[31:0],
           p0[63:32] ^ x_i[127:96] ^ k_i[63:32],
           p1[31:0],
           p1[63:32] ^ x_i[63:32] ^ k_i[31:0]};
    k_o = {k_i[63:32] + PHILOX_W1, k_i[31:0] + PHILOX_W0};
  end
endmodule

// File: rtl/philox4x32_stream.sv
// Streaming Philox-4x32 generator: UNROLL rounds per clock, auto-incrementing counter,
// one-deep output buffer. Defining PHILOX_STATS_EN adds the blk_count transfer counter.
module philox4x32_stream
  import philox_pkg::*;
#(
  parameter int ROUNDS = 10,
  parameter int UNROLL = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_load,
  input  logic [STATE_W-1:0]  cfg_counter,
  input  logic [KEY_W-1:0]    cfg_key,
  input  logic                en,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [STATE_W-1:0]  out_data
`ifdef PHILOX_STATS_EN
  ,
  output logic [31:0]         blk_count
`endif
);
  localparam int CYCLES = ROUNDS / UNROLL;
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] RCNT_LAST = CW'(CYCLES - 1);

  if (ROUNDS < 1 || UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_cfg
    $error("philox4x32_stream: UNROLL must divide ROUNDS and both must be >= 1");
  end

  philox_state_e      state_q, state_d;
  logic [STATE_W-1:0] ctr_q, ctr_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [STATE_W-1:0] x_q, x_d;
  logic [KEY_W-1:0]   rkey_q, rkey_d;
  logic [CW-1:0]      rcnt_q, rcnt_d;
  logic               out_valid_q, out_valid_d;
  logic [STATE_W-1:0] out_data_q, out_data_d;

  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    logic [STATE_W-1:0] xi, xo;
    logic [KEY_W-1:0]   ki, ko;
    if (g == 0) begin : g_first
      assign xi = x_q;
      assign ki = rkey_q;
    end else begin : g_next
      assign xi = g_rnd[g-1].xo;
      assign ki = g_rnd[g-1].ko;
    end
    philox_round u_round (.x_i(xi), .k_i(ki), .x_o(xo), .k_o(ko));
  end

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr_q;
    key_d       = key_q;
    x_d         = x_q;
    rkey_d      = rkey_q;
    rcnt_d      = rcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (cfg_load) begin
      ctr_d       = cfg_counter;
      key_d       = cfg_key;
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_d = ST_RUN;
            x_d     = ctr_q;
            rkey_d  = key_q;
            rcnt_d  = '0;
            ctr_d   = ctr_q + 1'b1;
          end
        end
        ST_RUN: begin
          x_d    = g_rnd[UNROLL-1].xo;
          rkey_d = g_rnd[UNROLL-1].ko;
          rcnt_d = rcnt_q + CW'(1);
          if (rcnt_q == RCNT_LAST) state_d = ST_DONE;
        end
        ST_DONE: begin
          // The buffer frees up this cycle if empty or being drained; otherwise hold the result.
          if (!out_valid_q || out_ready) begin
            out_data_d  = x_q;
            out_valid_d = 1'b1;
            if (en) begin
              state_d = ST_RUN;
              x_d     = ctr_q;
              rkey_d  = key_q;
              rcnt_d  = '0;
              ctr_d   = ctr_q + 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ctr_q       <= '0;
      key_q       <= '0;
      x_q         <= '0;
      rkey_q      <= '0;
      rcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      key_q       <= key_d;
      x_q         <= x_d;
      rkey_q      <= rkey_d;
      rcnt_q      <= rcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef PHILOX_STATS_EN
  logic [31:0] blk_count_q, blk_count_d;

  always_comb begin
    blk_count_d = blk_count_q;
    if (cfg_load) blk_count_d = '0;
    else if (out_valid_q && out_ready && (blk_count_q != 32'hFFFF_FFFF))
      blk_count_d = blk_count_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blk_count_q <= '0;
    else        blk_count_q <= blk_count_d;
  end

  assign blk_count = blk_count_q;
`endif
endmodule

// File: tb/tb_philox4x32_stream.sv
// Scoreboard bench for philox4x32_stream: known-answer vectors, stream order, latency,
// backpressure, cfg_load abort, en deassert and asynchronous reset.
module tb_philox4x32_stream;
  localparam int ROUNDS  = 10;
  localparam int UNROLL  = 1;
  localparam int BLK_CYC = ROUNDS / UNROLL + 1;
  localparam logic [127:0] KAT_ZERO = 128'h9b00dbd8_bc57ac4c_e169c58d_6627e8d5;
  localparam logic [127:0] KAT_ONES = 128'h6d5451fd_a20bc7c6_41c83b0e_408f276d;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         cfg_load = 1'b0;
  logic [127:0] cfg_counter = '0;
  logic [63:0]  cfg_key = '0;
  logic         en = 1'b0;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         out_valid;
  logic [127:0] out_data;
`ifdef PHILOX_STATS_EN
  logic [31:0]  blk_count;
`endif

  philox4x32_stream #(.ROUNDS(ROUNDS), .UNROLL(UNROLL)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_counter(cfg_counter),
    .cfg_key(cfg_key), .en(en), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
`ifdef PHILOX_STATS_EN
    , .blk_count(blk_count)
`endif
  );

  int checks = 0;
  int fails = 0;
  int xfer_cnt = 0;
  int cyc_cnt = 0;
  logic [127:0] exp_q[$];
  int xfer_cyc[$];
  logic [127:0] m_ctr;
  logic [63:0]  m_key;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [127:0] ref_block(input logic [127:0] c, input logic [63:0] k);
    logic [31:0] x0, x1, x2, x3, k0, k1;
    logic [63:0] p0, p1;
    {x3, x2, x1, x0} = c;
    {k1, k0} = k;
    for (int r = 0; r < ROUNDS; r++) begin
      p0 = 64'(x0) * 64'(32'hD2511F53);
      p1 = 64'(x2) * 64'(32'hCD9E8D57);
      x0 = p1[63:32] ^ x1 ^ k0;
      x1 = p1[31:0];
      x2 = p0[63:32] ^ x3 ^ k1;
      x3 = p0[31:0];
      k0 = k0 + 32'h9E3779B9;
      k1 = k1 + 32'hBB67AE85;
    end
    return {x3, x2, x1, x0};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // scoreboard monitor: a transfer completes on the posedge following this sample
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_block: got %h expected no block", out_data);
      end else begin
        check("stream_block", out_data, exp_q.pop_front());
      end
      xfer_cnt++;
      xfer_cyc.push_back(cyc_cnt);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [127:0] c, input logic [63:0] k);
    cfg_counter = c;
    cfg_key     = k;
    cfg_load    = 1'b1;
    en          = 1'b0;
    out_ready   = 1'b0;
    step(1);
    cfg_load = 1'b0;
    m_ctr    = c;
    m_key    = k;
  endtask

  task automatic expect_blocks(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ref_block(m_ctr, m_key));
      m_ctr = m_ctr + 1'b1;
    end
  endtask

  task automatic wait_xfers(input string name, input int target, input int budget);
    int b;
    b = 0;
    while (xfer_cnt < target && b < budget) begin
      step(1);
      b++;
    end
    check(name, 128'(xfer_cnt), 128'(target));
  endtask

  task automatic wait_valid(input string name, input int budget, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < budget) begin
      step(1);
      cyc++;
    end
    check(name, 128'(out_valid), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, base, bad;
    logic [127:0] held;

    // reset state
    step(3);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;
    step(1);

    // known-answer zero block, latency and steady throughput
    do_load(128'd0, 64'd0);
    exp_q.push_back(KAT_ZERO);
    m_ctr = 128'd1;
    expect_blocks(3);
    base = xfer_cnt;
    en = 1'b1;
    out_ready = 1'b1;
    wait_valid("zero_valid", 50, lat);
    check("latency", 128'(lat - 1), 128'(BLK_CYC));
    wait_xfers("zero_xfers", base + 4, 100);
    en = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i < 4; i++)
      check("throughput", 128'(xfer_cyc[base+i] - xfer_cyc[base+i-1]), 128'(BLK_CYC));

    // known-answer all-ones block; counter then wraps to zero
    do_load({128{1'b1}}, {64{1'b1}});
    exp_q.push_back(KAT_ONES);
    m_ctr = 128'd0;
    expect_blocks(1);
    base = xfer_cnt;
    en = 1'b1;
    out_ready = 1'b1;
    wait_xfers("ones_xfers", base + 2, 60);
    en = 1'b0;
    out_ready = 1'b0;

    // backpressure: buffered block must hold while the next one waits in DONE
    do_load(128'd100, 64'h0123_4567_89ab_cdef);
    expect_blocks(2);
    en = 1'b1;
    wait_valid("bp_valid", 50, lat);
    held = out_data;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (out_data !== held || out_valid !== 1'b1) bad++;
    end
    check("bp_stable_cycles_bad", 128'(bad), 128'(0));
    check("bp_busy_done", 128'(busy), 128'(1));
    en = 1'b0;
    out_ready = 1'b1;
    base = xfer_cnt;
    wait_xfers("bp_release_xfers", base + 2, 20);
    step(30);
    check("bp_idle_busy", 128'(busy), 128'(0));
    check("bp_idle_valid", 128'(out_valid), 128'(0));
    out_ready = 1'b0;

    // cfg_load while running with a block still buffered
    do_load(128'd1000, 64'h1111_2222_3333_4444);
    en = 1'b1;
    wait_valid("abort_pre_valid", 50, lat);
    step(3);
    check("abort_pre_busy", 128'(busy), 128'(1));
    do_load(128'd5, 64'hdead_beef_cafe_f00d);
    check("abort_valid_drop", 128'(out_valid), 128'(0));
    check("abort_busy_drop", 128'(busy), 128'(0));
    expect_blocks(3);
    base = xfer_cnt;
    en = 1'b1;
    out_ready = 1'b1;
    wait_xfers("abort_xfers", base + 3, 80);
    en = 1'b0;
    out_ready = 1'b0;

    // en dropped mid-block: that block still arrives, nothing after it
    do_load(128'd200, 64'h5555_6666_7777_8888);
    expect_blocks(1);
    base = xfer_cnt;
    en = 1'b1;
    out_ready = 1'b1;
    step(4);
    en = 1'b0;
    wait_xfers("en_drop_xfers", base + 1, 30);
    step(20);
    check("en_drop_busy", 128'(busy), 128'(0));
    check("en_drop_valid", 128'(out_valid), 128'(0));
    out_ready = 1'b0;

    // asynchronous reset mid-block with a buffered result
    do_load(128'd300, 64'h9999_aaaa_bbbb_cccc);
    en = 1'b1;
    wait_valid("arst_pre_valid", 50, lat);
    step(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_out_data", out_data, 128'(0));
    check("arst_busy", 128'(busy), 128'(0));
`ifdef PHILOX_STATS_EN
    check("arst_blk_count", 128'(blk_count), 128'(0));
`endif
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // after reset the counter and key are zero again
    exp_q.push_back(KAT_ZERO);
    m_ctr = 128'd1;
    m_key = 64'd0;
    expect_blocks(2);
    base = xfer_cnt;
    en = 1'b1;
    out_ready = 1'b1;
    wait_xfers("post_rst_xfers", base + 3, 80);
    en = 1'b0;
    out_ready = 1'b0;
`ifdef PHILOX_STATS_EN
    check("blk_count_3", 128'(blk_count), 128'(3));
`endif
    step(2);

    check("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end
endmodule
